seq_scan_ctrl: RTL and testbench

- Controller that sequences a programmable serial pattern detector for the tile.
- Accepts bytes over a valid/ready handshake and serializes them MSB-first into an internal matching window.
- Detects a configurable 1-8 bit pattern, with overlapping matches allowed, and counts matches in a saturating counter.
- Sits between the tile's parallel input pins and the detector/status outputs; the detector datapath is sequenced entirely by this block.

---
 rtl/seq_scan_pkg.sv | 13 +
 rtl/seq_match_core.sv | 47 ++++
 rtl/seq_scan_ctrl.sv | 110 +++++++++++
 tb/tb_seq_scan_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_scan_pkg.sv
// Shared constants and state encoding for the serial pattern scan controller.
package seq_scan_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam logic [BYTE_W-1:0] DEF_PATTERN = 8'h05;
    localparam logic [2:0] DEF_LEN = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_e;

endpackage

// File: rtl/seq_match_core.sv
// Matching window: 8-bit history shift register, fill counter and masked
// pattern compare. Raises match combinationally on the completing shift.
module seq_match_core
    import seq_scan_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              clear,
    input  logic              bit_in,
    input  logic [BYTE_W-1:0] pattern,
    input  logic [2:0]        len,
    output logic              match
);

    logic [BYTE_W-1:0] window_q, window_d, mask;
    logic [3:0]        fill_q, fill_d;

    always_comb begin
        window_d = window_q;
        fill_d   = fill_q;
        if (clear) begin
            window_d = '0;
            fill_d   = '0;
        end else if (shift_en) begin
            window_d = {window_q[BYTE_W-2:0], bit_in};
            if (fill_q != 4'd8) begin
                fill_d = fill_q + 4'd1;
            end
        end
        // Only the low len+1 window bits take part in the compare.
        mask  = 8'hFF >> (3'd7 - len);
        match = shift_en && (((window_d ^ pattern) & mask) == '0)
                && (fill_d > {1'b0, len});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_q <= '0;
            fill_q   <= '0;
        end else begin
            window_q <= window_d;
            fill_q   <= fill_d;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Byte-serializing controller for the pattern detector: handshake, FSM,
// MSB-first serializer, configuration registers and saturating match counter.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter logic [7:0]  DEFAULT_PATTERN = DEF_PATTERN,
    parameter logic [2:0]  DEFAULT_LEN     = DEF_LEN,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_pattern,
    input  logic [2:0]       cfg_len,
    input  logic             clr_count,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             bit_out,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic [1:0]       present_state
);

    state_e            state_q;
    logic [2:0]        bit_idx_q;
    logic [BYTE_W-1:0] shreg_q;
    logic [BYTE_W-1:0] pattern_q;
    logic [2:0]        len_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pulse_q;
    logic              last_bit, accept, shift_en, cfg_load, match;

    assign last_bit = (state_q == ST_SHIFT) && (bit_idx_q == 3'd7);
    assign in_ready = ena && ((state_q == ST_IDLE) || last_bit);
    assign accept   = in_valid && in_ready;
    assign shift_en = ena && (state_q == ST_SHIFT);
    assign cfg_load = ena && cfg_we && (state_q == ST_IDLE);

    seq_match_core u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .clear    (cfg_load),
        .bit_in   (shreg_q[BYTE_W-1]),
        .pattern  (pattern_q),
        .len      (len_q),
        .match    (match)
    );

    always_comb begin
        count_d = count_q;
        if (clr_count) begin
            count_d = '0;
        end else if (match && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            pattern_q <= DEFAULT_PATTERN;
            len_q     <= DEFAULT_LEN;
            count_q   <= '0;
            pulse_q   <= 1'b0;
        end else if (ena) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        shreg_q   <= in_data;
                        bit_idx_q <= '0;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shreg_q   <= {shreg_q[BYTE_W-2:0], 1'b0};
                    bit_idx_q <= bit_idx_q + 3'd1;
                    // Reload on the last bit gives gap-free streaming.
                    if (last_bit) begin
                        if (accept) begin
                            shreg_q   <= in_data;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (cfg_load) begin
                pattern_q <= cfg_pattern;
                len_q     <= cfg_len;
            end
            pulse_q <= match;
            count_q <= count_d;
        end
    end

    assign busy          = (state_q == ST_SHIFT);
    assign bit_out       = busy && shreg_q[BYTE_W-1];
    assign match_pulse   = pulse_q && ena;
    assign match_count   = count_q;
    assign present_state = state_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed scenarios plus randomized
// traffic, compared against a bit-queue reference model.
module tb_seq_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [2:0] cfg_len = '0;
    logic       clr_count = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, busy, bit_out, match_pulse;
    logic [7:0] match_count;
    logic [1:0] present_state;

    int n_total = 0;
    int n_pass  = 0;

    seq_scan_ctrl #(
        .DEFAULT_PATTERN (8'h05),
        .DEFAULT_LEN     (3'd2),
        .CNT_W           (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .cfg_we        (cfg_we),
        .cfg_pattern   (cfg_pattern),
        .cfg_len       (cfg_len),
        .clr_count     (clr_count),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .busy          (busy),
        .bit_out       (bit_out),
        .match_pulse   (match_pulse),
        .match_count   (match_count),
        .present_state (present_state)
    );

    always #5 clk = ~clk;

    // Reference model: bits still to enter the window, recent window history,
    // active pattern/length, registered pulse and count.
    bit         pend[$];
    bit         hist[$];
    logic [7:0] m_pat;
    int         m_len;
    int         m_cnt;
    bit         m_pulse;

    task automatic model_reset();
        pend.delete();
        hist.delete();
        m_pat   = 8'h05;
        m_len   = 2;
        m_cnt   = 0;
        m_pulse = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        int np;
        bit acc, m, b;
        if (!ena) return;
        np  = pend.size();
        acc = in_valid && (np <= 1);
        m   = 0;
        if (cfg_we && np == 0) begin
            m_pat = cfg_pattern;
            m_len = int'(cfg_len);
            hist.delete();
        end
        if (np > 0) begin
            b = pend.pop_front();
            hist.push_back(b);
            if (hist.size() > 8) void'(hist.pop_front());
            if (hist.size() >= m_len + 1) begin
                m = 1;
                for (int i = 0; i <= m_len; i++)
                    if (hist[hist.size() - 1 - i] != m_pat[i]) m = 0;
            end
        end
        m_pulse = m;
        if (clr_count) m_cnt = 0;
        else if (m && m_cnt < 255) m_cnt++;
        if (acc)
            for (int i = 7; i >= 0; i--) pend.push_back(in_data[i]);
    endtask

    function automatic bit exp_ready();
        return ena && (pend.size() <= 1);
    endfunction

    function automatic bit exp_busy();
        return pend.size() > 0;
    endfunction

    function automatic bit exp_bit_out();
        return (pend.size() > 0) ? pend[0] : 1'b0;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ena = 1'b1; cfg_we = 1'b0; clr_count = 1'b0;
        in_valid = 1'b0; in_data = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic start_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (match_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", match_count); else n_pass++;
        n_total++; if (present_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", present_state); else n_pass++;
        n_total++; if (match_pulse !== 1'b0) $display("FAIL reset_pulse: got %b want 0", match_pulse); else n_pass++;
        n_total++; if (bit_out !== 1'b0) $display("FAIL reset_bit_out: got %b want 0", bit_out); else n_pass++;
    endtask

    task automatic test_default_pattern();
        logic [7:0] pulses = '0;
        logic [7:0] bits   = '0;
        int busy_cyc = 0;
        do_reset();
        start_byte(8'hAA);
        for (int i = 0; i < 8; i++) begin
            if (busy) busy_cyc++;
            bits[7 - i] = bit_out;
            tick();
            pulses[i] = match_pulse;
        end
        n_total++; if (bits !== 8'hAA) $display("FAIL aa_bit_order: got %h want aa", bits); else n_pass++;
        n_total++; if (pulses !== 8'b0101_0100) $display("FAIL aa_pulse_pos: got %b want 01010100", pulses); else n_pass++;
        n_total++; if (busy_cyc != 8) $display("FAIL aa_busy_cycles: got %0d want 8", busy_cyc); else n_pass++;
        n_total++; if (match_count !== 8'd3) $display("FAIL aa_count: got %0d want 3", match_count); else n_pass++;
        n_total++; if (present_state !== 2'd0) $display("FAIL aa_idle: got %0d want 0", present_state); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int accepted = 0;
        int busy_cyc = 0;
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int k = 0; k <= 16; k++) begin
            if (in_valid && pend.size() <= 1) accepted++;
            tick();
            if (accepted == 2) in_valid = 1'b0;
            if (k == 7) begin
                n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_bit7: got %b want 1", in_ready); else n_pass++;
            end
            if (busy) busy_cyc++;
        end
        n_total++; if (busy_cyc != 16) $display("FAIL b2b_busy_cycles: got %0d want 16", busy_cyc); else n_pass++;
        n_total++; if (match_count !== 8'd7) $display("FAIL b2b_count: got %0d want 7", match_count); else n_pass++;
    endtask

    task automatic test_cfg_long();
        int npulse = 0;
        do_reset();
        cfg_we = 1'b1; cfg_pattern = 8'hFF; cfg_len = 3'd7;
        tick();
        cfg_we = 1'b0;
        start_byte(8'hFF);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (match_pulse) npulse++;
            if (i == 7) begin
                n_total++; if (match_pulse !== 1'b1) $display("FAIL len8_pulse_bit8: got %b want 1", match_pulse); else n_pass++;
            end
        end
        n_total++; if (npulse != 1) $display("FAIL len8_pulses: got %0d want 1", npulse); else n_pass++;
        n_total++; if (match_count !== 8'd1) $display("FAIL len8_count: got %0d want 1", match_count); else n_pass++;
        npulse = 0;
        start_byte(8'h7F);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (match_pulse) npulse++;
        end
        n_total++; if (npulse != 0) $display("FAIL len8_7f_pulses: got %0d want 0", npulse); else n_pass++;
        n_total++; if (match_count !== 8'd1) $display("FAIL len8_7f_count: got %0d want 1", match_count); else n_pass++;
    endtask

    task automatic test_saturate_clear();
        int accepted = 0;
        do_reset();
        cfg_we = 1'b1; cfg_pattern = 8'h01; cfg_len = 3'd0;
        tick();
        cfg_we = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int k = 0; k < 300 && (accepted < 32 || pend.size() > 0); k++) begin
            if (in_valid && pend.size() <= 1) accepted++;
            tick();
            if (accepted == 32) in_valid = 1'b0;
        end
        n_total++; if (match_count !== 8'd255) $display("FAIL sat_count: got %0d want 255", match_count); else n_pass++;
        start_byte(8'hFF);
        tick();
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        n_total++; if (match_pulse !== 1'b1) $display("FAIL clr_in_match_pulse: got %b want 1", match_pulse); else n_pass++;
        n_total++; if (match_count !== 8'd0) $display("FAIL clr_priority: got %0d want 0", match_count); else n_pass++;
        for (int i = 0; i < 6; i++) tick();
        n_total++; if (match_count !== 8'd6) $display("FAIL clr_recount: got %0d want 6", match_count); else n_pass++;
    endtask

    task automatic test_ena_freeze();
        bit frozen_bit;
        do_reset();
        start_byte(8'hAA);
        for (int i = 0; i < 3; i++) tick();
        frozen_bit = exp_bit_out();
        ena = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++; if (in_ready !== 1'b0) $display("FAIL ena_ready: got %b want 0", in_ready); else n_pass++;
            n_total++; if (match_pulse !== 1'b0) $display("FAIL ena_pulse: got %b want 0", match_pulse); else n_pass++;
            n_total++; if (match_count !== 8'd1) $display("FAIL ena_count: got %0d want 1", match_count); else n_pass++;
            n_total++; if (bit_out !== frozen_bit) $display("FAIL ena_bit_out: got %b want %b", bit_out, frozen_bit); else n_pass++;
        end
        ena = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_total++; if (match_pulse !== m_pulse) $display("FAIL ena_resume_pulse: got %b want %b", match_pulse, m_pulse); else n_pass++;
        end
        n_total++; if (match_count !== 8'd3) $display("FAIL ena_resume_count: got %0d want 3", match_count); else n_pass++;
    endtask

    task automatic test_cfg_during_shift();
        do_reset();
        start_byte(8'hAA);
        cfg_we = 1'b1; cfg_pattern = 8'hFF; cfg_len = 3'd7;
        for (int i = 0; i < 3; i++) tick();
        cfg_we = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_total++; if (match_count !== 8'd3) $display("FAIL cfg_busy_ignored: got %0d want 3", match_count); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        start_byte(8'hAA);
        for (int i = 0; i < 4; i++) tick();
        n_total++; if (match_count !== 8'd1) $display("FAIL arst_pre_count: got %0d want 1", match_count); else n_pass++;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (present_state !== 2'd0) $display("FAIL arst_state: got %0d want 0", present_state); else n_pass++;
        n_total++; if (match_count !== 8'd0) $display("FAIL arst_count: got %0d want 0", match_count); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL arst_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (bit_out !== 1'b0) $display("FAIL arst_bit_out: got %b want 0", bit_out); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_data     = 8'($urandom);
            ena         = ($urandom_range(0, 9) != 0);
            clr_count   = ($urandom_range(0, 39) == 0);
            cfg_we      = ($urandom_range(0, 29) == 0);
            cfg_pattern = 8'($urandom);
            cfg_len     = 3'($urandom_range(0, 3));
            tick();
            n_total++; if (in_ready !== exp_ready()) $display("FAIL rnd_ready @%0d: got %b want %b", k, in_ready, exp_ready()); else n_pass++;
            n_total++; if (busy !== exp_busy()) $display("FAIL rnd_busy @%0d: got %b want %b", k, busy, exp_busy()); else n_pass++;
            n_total++; if (present_state !== {1'b0, exp_busy()}) $display("FAIL rnd_state @%0d: got %0d want %0d", k, present_state, exp_busy()); else n_pass++;
            n_total++; if (bit_out !== exp_bit_out()) $display("FAIL rnd_bit_out @%0d: got %b want %b", k, bit_out, exp_bit_out()); else n_pass++;
            n_total++; if (match_pulse !== (m_pulse && ena)) $display("FAIL rnd_pulse @%0d: got %b want %b", k, match_pulse, m_pulse && ena); else n_pass++;
            n_total++; if (match_count !== 8'(m_cnt)) $display("FAIL rnd_count @%0d: got %0d want %0d", k, match_count, m_cnt); else n_pass++;
        end
        in_valid = 1'b0; cfg_we = 1'b0; clr_count = 1'b0; ena = 1'b1;
    endtask

    initial begin
        test_reset();
        test_default_pattern();
        test_back_to_back();
        test_cfg_long();
        test_saturate_clear();
        test_ena_freeze();
        test_cfg_during_shift();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
